// File: rtl/alu_div_pkg.sv
// Shared types and sizing helpers for the sequential divider.
package alu_div_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    RUN,
    FIX,
    DONE
  } div_state_t;

  // Iteration counter width; holds WIDTH-1.
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/nr_div_step.sv
// One non-restoring iteration: shift {A,Q} left, add/subtract M, retire one quotient bit.
// Purely combinational; the add/subtract uses a parallel-prefix carry-lookahead adder.
module cla_adder #(
  parameter int N = 33
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum
);
  // Prefix tree covers the low N-1 bits; the MSB carry-out is never needed.
  localparam int M = N - 1;
  localparam int L = $clog2(M);

  logic [N-1:0]        p0;
  logic [L:0][M-1:0]   g;
  logic [L-1:0][M-1:0] p;

  assign p0   = a ^ b;
  assign p[0] = p0[M-1:0];
  assign g[0] = (a[M-1:0] & b[M-1:0]) | {{(M-1){1'b0}}, p0[0] & cin};

  for (genvar k = 0; k < L; k++) begin : g_lvl
    for (genvar i = 0; i < M; i++) begin : g_bit
      if (i >= (1 << k)) begin : g_merge
        assign g[k+1][i] = g[k][i] | (p[k][i] & g[k][i-(1<<k)]);
        if (k + 1 < L) begin : g_prop
          assign p[k+1][i] = p[k][i] & p[k][i-(1<<k)];
        end
      end else begin : g_pass
        assign g[k+1][i] = g[k][i];
        if (k + 1 < L) begin : g_prop
          assign p[k+1][i] = p[k][i];
        end
      end
    end
  end

  assign sum = p0 ^ {g[L], cin};

endmodule

module nr_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   a,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH:0]   a_next,
  output logic [WIDTH-1:0] q_next
);
  logic             sub;
  logic [WIDTH:0]   a_sh;
  logic [WIDTH:0]   operand;

  // Direction comes from the sign of A before the shift.
  assign sub     = ~a[WIDTH];
  assign a_sh    = {a[WIDTH-1:0], q[WIDTH-1]};
  assign operand = sub ? ~{1'b0, m} : {1'b0, m};

  cla_adder #(.N(WIDTH + 1)) u_add (
    .a   (a_sh),
    .b   (operand),
    .cin (sub),
    .sum (a_next)
  );

  assign q_next = {q[WIDTH-2:0], ~a_next[WIDTH]};

endmodule

// File: rtl/seq_non_restoring_div.sv
// Sequential non-restoring divider, signed/unsigned; latency WIDTH+2 cycles (1 on divide-by-zero).
// Result held in DONE until out_ready; in_ready is low from acceptance until the result handshake.
module seq_non_restoring_div
  import alu_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             is_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  div_state_t       state, state_next;
  logic [CW-1:0]    counter;
  logic [WIDTH-1:0] op_dividend, op_divisor;
  logic             op_signed;
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] qreg, mreg;
  logic             q_neg, r_neg;
  logic [WIDTH:0]   a_step;
  logic [WIDTH-1:0] q_step;
  logic [WIDTH-1:0] mag_dividend, mag_divisor, rem_mag;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (in_valid) state_next = (divisor == '0) ? DONE : PREP;
        PREP:    state_next = RUN;
        RUN:     if (counter == '0) state_next = FIX;
        FIX:     state_next = DONE;
        DONE:    if (out_ready) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // |MIN| = 2^(WIDTH-1) still fits as an unsigned magnitude.
  assign mag_dividend = (op_signed && op_dividend[WIDTH-1]) ? -op_dividend : op_dividend;
  assign mag_divisor  = (op_signed && op_divisor[WIDTH-1])  ? -op_divisor  : op_divisor;
  assign rem_mag      = acc[WIDTH] ? acc[WIDTH-1:0] + mreg : acc[WIDTH-1:0];

  nr_div_step #(.WIDTH(WIDTH)) u_step (
    .a      (acc),
    .q      (qreg),
    .m      (mreg),
    .a_next (a_step),
    .q_next (q_step)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      counter     <= '0;
      op_dividend <= '0;
      op_divisor  <= '0;
      op_signed   <= 1'b0;
      acc         <= '0;
      qreg        <= '0;
      mreg        <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
    end else if (!flush) begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_dividend <= dividend;
            op_divisor  <= divisor;
            op_signed   <= is_signed;
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end
          end
        end
        PREP: begin
          q_neg   <= op_signed & (op_dividend[WIDTH-1] ^ op_divisor[WIDTH-1]);
          r_neg   <= op_signed & op_dividend[WIDTH-1];
          acc     <= '0;
          qreg    <= mag_dividend;
          mreg    <= mag_divisor;
          counter <= CNT_LAST;
        end
        RUN: begin
          acc  <= a_step;
          qreg <= q_step;
          if (counter != '0) counter <= counter - 1'b1;
        end
        FIX: begin
          quotient    <= q_neg ? -qreg : qreg;
          remainder   <= r_neg ? -rem_mag : rem_mag;
          div_by_zero <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_non_restoring_div.sv
module tb_seq_non_restoring_div;

  typedef struct {
    logic [63:0] q;
    logic [63:0] r;
    logic        z;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;

  logic        a_in_valid = 1'b0, a_in_ready, a_is_signed = 1'b0;
  logic [31:0] a_dividend = '0, a_divisor = '0;
  logic        a_out_valid, a_out_ready = 1'b0, a_dbz;
  logic [31:0] a_quotient, a_remainder;

  logic        b_in_valid = 1'b0, b_in_ready, b_is_signed = 1'b0;
  logic [7:0]  b_dividend = '0, b_divisor = '0;
  logic        b_out_valid, b_out_ready = 1'b0, b_dbz;
  logic [7:0]  b_quotient, b_remainder;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_non_restoring_div #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .dividend(a_dividend), .divisor(a_divisor), .is_signed(a_is_signed),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .quotient(a_quotient), .remainder(a_remainder), .div_by_zero(a_dbz)
  );

  seq_non_restoring_div #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .dividend(b_dividend), .divisor(b_divisor), .is_signed(b_is_signed),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .quotient(b_quotient), .remainder(b_remainder), .div_by_zero(b_dbz)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Truncating-division reference built on the simulator's own arithmetic.
  function automatic exp_t model(input int w, input logic [63:0] a, input logic [63:0] b, input logic s);
    exp_t e;
    logic [63:0] mask;
    longint sa, sd;
    mask = (64'd1 << w) - 64'd1;
    a = a & mask;
    b = b & mask;
    if (b == 64'd0) begin
      e.q = mask; e.r = a; e.z = 1'b1;
    end else if (s) begin
      sa = $signed(a << (64 - w)) >>> (64 - w);
      sd = $signed(b << (64 - w)) >>> (64 - w);
      e.q = 64'(sa / sd) & mask;
      e.r = 64'(sa % sd) & mask;
      e.z = 1'b0;
    end else begin
      e.q = a / b; e.r = a % b; e.z = 1'b0;
    end
    return e;
  endfunction

  task automatic send(input bit w8, input logic [63:0] a, input logic [63:0] b, input logic s,
                      output int acc_cyc);
    int n;
    if (w8) begin
      b_in_valid = 1'b1; b_dividend = a[7:0]; b_divisor = b[7:0]; b_is_signed = s;
    end else begin
      a_in_valid = 1'b1; a_dividend = a[31:0]; a_divisor = b[31:0]; a_is_signed = s;
    end
    n = 0;
    while (!(w8 ? b_in_ready : a_in_ready) && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) check("accept_timeout", 64'd0, 64'd1);
    tick();
    acc_cyc = cyc;
    a_in_valid = 1'b0;
    b_in_valid = 1'b0;
  endtask

  task automatic wait_valid(input bit w8, input string tag, output bit ok);
    int n;
    n = 0;
    while (!(w8 ? b_out_valid : a_out_valid) && n < 200) begin
      tick();
      n++;
    end
    ok = (w8 ? b_out_valid : a_out_valid);
    if (!ok) check({tag, "_valid_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic receive(input bit w8, input string tag, output int at_cyc);
    bit   ok;
    exp_t e;
    wait_valid(w8, tag, ok);
    at_cyc = cyc;
    if (sb.size() == 0) begin
      check({tag, "_scoreboard_empty"}, 64'd0, 64'd1);
      return;
    end
    e = sb.pop_front();
    if (!ok) return;
    if (w8) begin
      check({tag, "_q"}, {56'd0, b_quotient}, e.q);
      check({tag, "_r"}, {56'd0, b_remainder}, e.r);
      check({tag, "_dbz"}, {63'd0, b_dbz}, {63'd0, e.z});
      b_out_ready = 1'b1;
    end else begin
      check({tag, "_q"}, {32'd0, a_quotient}, e.q);
      check({tag, "_r"}, {32'd0, a_remainder}, e.r);
      check({tag, "_dbz"}, {63'd0, a_dbz}, {63'd0, e.z});
      a_out_ready = 1'b1;
    end
    tick();
    a_out_ready = 1'b0;
    b_out_ready = 1'b0;
  endtask

  task automatic watch_quiet(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (a_out_valid) seen = 1'b1;
      tick();
    end
    check(tag, {63'd0, seen}, 64'd0);
  endtask

  task automatic run_op(input bit w8, input string tag, input logic [63:0] a,
                        input logic [63:0] b, input logic s);
    int t0, t1;
    sb.push_back(model(w8 ? 8 : 32, a, b, s));
    send(w8, a, b, s, t0);
    receive(w8, tag, t1);
  endtask

  initial begin
    int t0, t1;
    bit ok;
    logic [7:0] corner [6];
    logic [63:0] ra, rb;

    // Reset state while rst_n is low.
    repeat (3) tick();
    check("rst_out_valid", {63'd0, a_out_valid}, 64'd0);
    check("rst_quotient", {32'd0, a_quotient}, 64'd0);
    check("rst_remainder", {32'd0, a_remainder}, 64'd0);
    check("rst_dbz", {63'd0, a_dbz}, 64'd0);
    check("rst_in_ready", {63'd0, a_in_ready}, 64'd1);
    rst_n = 1'b1;
    tick();

    // 100 / 7 unsigned with exact latency.
    sb.push_back('{q: 64'd14, r: 64'd2, z: 1'b0});
    send(1'b0, 64'd100, 64'd7, 1'b0, t0);
    receive(1'b0, "u100_7", t1);
    check("u100_7_latency", 64'(t1 - t0), 64'd34);

    // Signed sign handling.
    sb.push_back('{q: 64'hFFFF_FFFD, r: 64'hFFFF_FFFF, z: 1'b0});
    send(1'b0, 64'hFFFF_FFF9, 64'd2, 1'b1, t0);
    receive(1'b0, "s_m7_2", t1);
    sb.push_back('{q: 64'hFFFF_FFFD, r: 64'd1, z: 1'b0});
    send(1'b0, 64'd7, 64'hFFFF_FFFE, 1'b1, t0);
    receive(1'b0, "s_7_m2", t1);

    // Signed overflow MIN / -1.
    sb.push_back('{q: 64'h8000_0000, r: 64'd0, z: 1'b0});
    send(1'b0, 64'h8000_0000, 64'hFFFF_FFFF, 1'b1, t0);
    receive(1'b0, "s_min_m1", t1);

    // Divide by zero: result in the cycle right after acceptance.
    sb.push_back('{q: 64'hFFFF_FFFF, r: 64'd5, z: 1'b1});
    send(1'b0, 64'd5, 64'd0, 1'b0, t0);
    check("dbz_valid_next_cycle", {63'd0, a_out_valid}, 64'd1);
    receive(1'b0, "u5_0", t1);
    sb.push_back('{q: 64'hFFFF_FFFF, r: 64'hFFFF_FFFB, z: 1'b1});
    send(1'b0, 64'hFFFF_FFFB, 64'd0, 1'b1, t0);
    receive(1'b0, "s_m5_0", t1);

    // Backpressure in DONE, then back-to-back.
    sb.push_back('{q: 64'd100, r: 64'd0, z: 1'b0});
    send(1'b0, 64'd1000, 64'd10, 1'b0, t0);
    wait_valid(1'b0, "bp", ok);
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_q", {32'd0, a_quotient}, 64'd100);
      check("bp_hold_valid", {63'd0, a_out_valid}, 64'd1);
      check("bp_in_ready_low", {63'd0, a_in_ready}, 64'd0);
      tick();
    end
    receive(1'b0, "bp", t1);
    check("b2b_in_ready", {63'd0, a_in_ready}, 64'd1);
    check("b2b_valid_low", {63'd0, a_out_valid}, 64'd0);
    sb.push_back('{q: 64'd16, r: 64'd2, z: 1'b0});
    send(1'b0, 64'd50, 64'd3, 1'b0, t0);
    receive(1'b0, "b2b", t1);

    // Reset during RUN cycle 10.
    send(1'b0, 64'd123456, 64'd789, 1'b0, t0);
    repeat (11) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_out_valid", {63'd0, a_out_valid}, 64'd0);
    check("midrst_in_ready", {63'd0, a_in_ready}, 64'd1);
    watch_quiet("midrst_no_result");

    // Flush in DONE discards the result.
    send(1'b0, 64'd9, 64'd3, 1'b0, t0);
    wait_valid(1'b0, "flush_done", ok);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_valid_drop", {63'd0, a_out_valid}, 64'd0);
    check("flush_in_ready", {63'd0, a_in_ready}, 64'd1);
    watch_quiet("flush_no_stale");

    // Flush cancels a same-cycle acceptance.
    a_in_valid = 1'b1; a_dividend = 32'd20; a_divisor = 32'd4; a_is_signed = 1'b0;
    flush = 1'b1;
    tick();
    a_in_valid = 1'b0;
    flush = 1'b0;
    check("flush_accept_cancel", {63'd0, a_in_ready}, 64'd1);
    watch_quiet("flush_accept_no_result");
    sb.push_back('{q: 64'd5, r: 64'd0, z: 1'b0});
    send(1'b0, 64'd20, 64'd4, 1'b0, t0);
    receive(1'b0, "after_flush", t1);

    // 32-bit random, both modes.
    for (int i = 0; i < 30; i++) begin
      ra = {32'd0, $urandom()};
      rb = {32'd0, $urandom() >> $urandom_range(0, 31)};
      run_op(1'b0, "r32", ra, rb, 1'(i & 1));
    end

    // WIDTH=8: corner cross-product plus random pairs, both modes.
    corner[0] = 8'h00; corner[1] = 8'h01; corner[2] = 8'h7F;
    corner[3] = 8'h80; corner[4] = 8'hFF; corner[5] = 8'h02;
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 6; i++)
        for (int j = 0; j < 6; j++)
          run_op(1'b1, "c8", {56'd0, corner[i]}, {56'd0, corner[j]}, 1'(s));
    for (int i = 0; i < 400; i++)
      run_op(1'b1, "r8", 64'($urandom_range(0, 255)), 64'($urandom_range(0, 255)), 1'(i & 1));

    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
